// File: rtl/alu_rr_arbiter.sv
// Round-robin front end that shares one fixed-latency select_action ALU between NUM_REQ
// requesters, with one operation in flight at a time.
module alu_rr_arbiter #(
    parameter int unsigned BITS    = 16,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned OP_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*BITS-1:0]   req_sw,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [BITS-1:0]           rsp_data,
    output logic [OP_W-1:0]           alu_sel,
    output logic [BITS-1:0]           alu_sw,
    input  logic [BITS-1:0]           alu_led,
    output logic                      busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(ALU_LAT + 2);
    localparam logic [PTR_W:0]   NUM_REQ_W = NUM_REQ[PTR_W:0];
    localparam logic [CNT_W-1:0] LAT_C     = ALU_LAT[CNT_W-1:0];
    localparam logic [OP_W-1:0]  OP_RESET  = '0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OP_W-1:0]     alu_sel_q, alu_sel_d;
    logic [BITS-1:0]     alu_sw_q, alu_sw_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [BITS-1:0]     rsp_data_q, rsp_data_d;

    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W:0]      scan_idx;
    logic [PTR_W:0]      ptr_inc;
    logic [OP_W-1:0]     grant_op;
    logic [BITS-1:0]     grant_sw;

    // First pending requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + k[PTR_W:0];
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!grant_found && req_valid[scan_idx[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        grant_op = '0;
        grant_sw = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_idx == k[PTR_W-1:0]) begin
                grant_op = req_op[k*OP_W +: OP_W];
                grant_sw = req_sw[k*BITS +: BITS];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == StIdle && !rst && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        alu_sel_d   = alu_sel_q;
        alu_sw_d    = alu_sw_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        ptr_inc     = {1'b0, grant_idx} + 1'b1;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    alu_sel_d = grant_op;
                    alu_sw_d  = grant_sw;
                    owner_d   = grant_idx;
                    rr_ptr_d  = (ptr_inc >= NUM_REQ_W) ? '0 : ptr_inc[PTR_W-1:0];
                    cnt_d     = '0;
                    state_d   = StWait;
                end
            end
            StWait: begin
                if (cnt_q == LAT_C) begin
                    rsp_data_d           = alu_led;
                    rsp_valid_d          = '0;
                    rsp_valid_d[owner_q] = 1'b1;
                    state_d              = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    alu_sel_d   = OP_RESET;
                    alu_sw_d    = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            alu_sel_q   <= OP_RESET;
            alu_sw_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            alu_sel_q   <= alu_sel_d;
            alu_sw_q    <= alu_sw_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign alu_sel   = alu_sel_q;
    assign alu_sw    = alu_sw_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: drivers push expected results on accept, a monitor
// pops and compares whenever a response is handed over, and checks grant order each cycle.
module tb_alu_rr_arbiter;

    localparam logic [1:0] OP_RST = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_MUL = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv[2];
    logic [1:0]  rop[2];
    logic [15:0] rsw[2];
    logic        rr[2];

    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]  req_op;
    logic [31:0] req_sw;
    logic [15:0] rsp_data, alu_sw, alu_led;
    logic [1:0]  alu_sel;
    logic        busy;

    assign req_valid = {rv[1], rv[0]};
    assign req_op    = {rop[1], rop[0]};
    assign req_sw    = {rsw[1], rsw[0]};
    assign rsp_ready = {rr[1], rr[0]};

    alu_rr_arbiter #(.BITS(16), .NUM_REQ(2), .ALU_LAT(2), .OP_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sw(req_sw),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_sel(alu_sel), .alu_sw(alu_sw), .alu_led(alu_led), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc_cyc[2];
    int rr_exp = 0;
    logic [1:0] prev_v = 2'b00;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    int grant_log[$];

    function automatic logic [15:0] alu_fn(input logic [1:0] op, input logic [15:0] sw);
        logic [15:0] a, b;
        a = {8'h00, sw[7:0]};
        b = {8'h00, sw[15:8]};
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            default: return 16'h0000;
        endcase
    endfunction

    // Two-stage select_action stand-in: LED follows SW/SELECTOR two posedges later.
    logic [15:0] alu_s1 = 16'h0000;
    logic [15:0] alu_s2 = 16'h0000;
    always @(posedge clk) begin
        alu_s1 <= alu_fn(alu_sel, alu_sw);
        alu_s2 <= alu_s1;
    end
    assign alu_led = alu_s2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic issue(input int r, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [15:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        rv[r]  = 1'b1;
        rop[r] = op;
        rsw[r] = {b, a};
        #1;
        while (!req_ready[r] && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready[r]) begin
            chk("grant_timeout", 32'(n), 32'd0);
            rv[r] = 1'b0;
            return;
        end
        @(posedge clk);
        if (r == 0) exp_q0.push_back(exp);
        else exp_q1.push_back(exp);
        grant_log.push_back(r);
        @(negedge clk);
        acc_cyc[r] = cyc;
        rv[r]  = 1'b0;
        rop[r] = 2'($urandom);
        rsw[r] = 16'hA5A5;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200);
        chk("drain_timeout", 32'(n >= 200), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: grant order, one-hot invariants, response latency and data.
    always @(negedge clk) begin
        int g;
        int idx;
        logic [15:0] e;
        #1;
        if (rst) begin
            rr_exp = 0;
            prev_v = 2'b00;
        end else begin
            chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            chk("rsp_valid_onehot", 32'($countones(rsp_valid) <= 1), 32'd1);
            if (busy) begin
                chk("ready_while_busy", 32'(req_ready), 32'd0);
            end else begin
                g = -1;
                for (int k = 0; k < 2; k++) begin
                    idx = (rr_exp + k) % 2;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
                chk("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
                if (g >= 0) rr_exp = (g + 1) % 2;
            end
            for (int i = 0; i < 2; i++) begin
                if (rsp_valid[i]) begin
                    if (!prev_v[i]) chk($sformatf("rsp_latency_req%0d", i),
                                        32'(cyc - acc_cyc[i]), 32'd3);
                    if (rr[i]) begin
                        if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                            chk($sformatf("unexpected_rsp_req%0d", i), 32'(rsp_data), 32'hDEAD);
                        end else begin
                            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            chk($sformatf("rsp_data_req%0d", i), 32'(rsp_data), 32'(e));
                        end
                    end
                end
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, c0, c1, maxd;
        logic [1:0] op;
        logic [7:0] a, b;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i] = 1'b0; rop[i] = '0; rsw[i] = '0; rr[i] = 1'b1; acc_cyc[i] = 0;
        end
        repeat (2) @(negedge clk);
        rv[0] = 1'b1;
        #1;
        chk("ready_in_reset", 32'(req_ready), 32'd0);
        chk("reset_alu_sel", 32'(alu_sel), 32'(OP_RST));
        chk("reset_alu_sw", 32'(alu_sw), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rv[0] = 1'b0;
        rst = 1'b0;

        // Single ops, hand-computed results.
        issue(0, OP_ADD, 8'd3, 8'd5, 16'd8);
        wait_idle();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_alu_sel", 32'(alu_sel), 32'(OP_RST));
        chk("idle_alu_sw", 32'(alu_sw), 32'd0);
        issue(1, OP_SUB, 8'd3, 8'd5, 16'hFFFE);
        wait_idle();
        issue(1, OP_MUL, 8'd255, 8'd255, 16'd65025);
        wait_idle();
        issue(1, OP_RST, 8'd7, 8'd9, 16'd0);
        wait_idle();
        issue(0, OP_SUB, 8'd0, 8'd1, 16'hFFFF);
        wait_idle();
        issue(0, OP_ADD, 8'd255, 8'd255, 16'd510);
        wait_idle();

        // Both requesting continuously from reset: strict 0,1,0,1 rotation.
        do_reset();
        mark = grant_log.size();
        fork
            begin
                issue(0, OP_ADD, 8'd1, 8'd2, 16'd3);
                issue(0, OP_MUL, 8'd16, 8'd16, 16'd256);
                issue(0, OP_SUB, 8'd10, 8'd4, 16'd6);
            end
            begin
                issue(1, OP_ADD, 8'd100, 8'd200, 16'd300);
                issue(1, OP_SUB, 8'd1, 8'd2, 16'hFFFF);
                issue(1, OP_MUL, 8'd2, 8'd128, 16'd256);
            end
        join
        wait_idle();
        for (int k = 0; k < 6; k++) chk("rotation_order", 32'(grant_log[mark + k]), 32'(k % 2));

        // Response back-pressure: owner stalls 5 cycles, non-owner ready is ignored.
        rr[0] = 1'b0;
        issue(0, OP_MUL, 8'd12, 8'd10, 16'd120);
        fork
            issue(1, OP_ADD, 8'd1, 8'd2, 16'd3);
            begin
                int n;
                n = 0;
                while (!rsp_valid[0] && n < 20) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                chk("stall_rsp_seen", 32'(rsp_valid[0]), 32'd1);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    #1;
                    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
                    chk("stall_rsp_data", 32'(rsp_data), 32'd120);
                    chk("stall_req_ready", 32'(req_ready), 32'd0);
                    chk("stall_alu_sw", 32'(alu_sw), 32'h0A0C);
                    chk("stall_alu_sel", 32'(alu_sel), 32'(OP_MUL));
                end
                @(negedge clk);
                rr[0] = 1'b1;
            end
        join
        wait_idle();

        // Reset one cycle after accept aborts the op and rewinds the pointer.
        issue(0, OP_ADD, 8'd1, 8'd1, 16'd2);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_alu_sel", 32'(alu_sel), 32'(OP_RST));
        chk("abort_alu_sw", 32'(alu_sw), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_q0.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        mark = grant_log.size();
        fork
            issue(0, OP_ADD, 8'd2, 8'd2, 16'd4);
            issue(1, OP_ADD, 8'd3, 8'd3, 16'd6);
        join
        wait_idle();
        chk("abort_first_grant", 32'(grant_log[mark]), 32'd0);

        // Mixed traffic, 200 ops; expected from the ALU reference function.
        mark = grant_log.size();
        fork
            for (int k = 0; k < 100; k++) begin
                op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
                issue(0, op, a, b, alu_fn(op, {b, a}));
            end
            for (int k = 0; k < 100; k++) begin
                op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
                issue(1, op, a, b, alu_fn(op, {b, a}));
            end
        join
        wait_idle();
        c0 = 0; c1 = 0; maxd = 0;
        for (int k = mark; k < grant_log.size(); k++) begin
            if (grant_log[k] == 0) c0++;
            else c1++;
            if (c0 - c1 > maxd) maxd = c0 - c1;
            if (c1 - c0 > maxd) maxd = c1 - c0;
        end
        chk("fairness_max_skew", 32'(maxd <= 1), 32'd1);
        chk("fairness_count0", 32'(c0), 32'd100);
        chk("fairness_count1", 32'(c1), 32'd100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
